pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, giving the redirect bubble length in cycles (legal range 1..3).
REQ-002 SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port id_opcode, input, 6 bits: opcode in the IF/ID register.
REQ-006 SHALL have ports id_rs and id_rt, input, 5 bits each: source register fields in IF/ID.
REQ-007 SHALL have port ex_opcode, input, 6 bits: opcode in the ID/EX register.
REQ-008 SHALL have port ex_rt, input, 5 bits: destination field of the instruction in EX.
REQ-009 SHALL have port ex_redirect, input, 1 bit: execute-stage branch-taken or jump request.
REQ-010 SHALL have ports mem_req and mem_ready, input, 1 bit each: data-memory access request and completion.
REQ-011 SHALL have ports pc_load, if_id_load, id_ex_load and ex_mem_load, output, 1 bit each: pipeline register enables.
REQ-012 SHALL have ports if_id_flush and id_ex_flush, output, 1 bit each: insert an EMPTY opcode bubble on the next edge.
REQ-013 SHALL have port ctrl_state, output, 2 bits: current FSM state.
REQ-014 SHALL have port stall_cnt, output, CNT_W bits: count of stalled cycles.

Function
REQ-015 SHALL implement FSM states RUN=0, REDIR=1, LDSTALL=2 and MEMWAIT=3.
REQ-016 SHALL, in RUN with no hazard, drive all four loads to 1 and both flushes to 0.
REQ-017 SHALL evaluate events in strict priority: memory wait, then redirect, then load-use.
REQ-018 SHALL define memory wait as mem_req=1 and mem_ready=0; the response is all loads 0 and flushes 0 in the same cycle, with the next state MEMWAIT.
REQ-019 SHALL, in MEMWAIT, hold all loads 0 until mem_ready=1; in the cycle mem_ready=1 it SHALL drive all loads 1 and return to RUN.
REQ-020 SHALL treat mem_req=1 together with mem_ready=1 in the same cycle as having no stall.
REQ-021 SHALL, on ex_redirect=1 in RUN, assert pc_load=1, if_id_flush=1 and id_ex_flush=1, load the redirect counter with FLUSH_CYCLES-1, and go to REDIR.
REQ-022 SHALL, in REDIR, keep the loads at 1, suppress load-use detection, and ignore ex_redirect, decrementing the counter each cycle; at count 0 it SHALL return to RUN.
REQ-023 SHALL, when FLUSH_CYCLES=1, spend exactly one cycle in REDIR.
REQ-024 SHALL detect load-use as: ex_opcode=LW, ex_rt!=0, and either ex_rt=id_rs, or ex_rt=id_rt where id_opcode is AR, BEQ, BNE or SW.
REQ-025 SHALL, on load-use in RUN, drive pc_load=0, if_id_load=0, id_ex_flush=1, id_ex_load=1 and ex_mem_load=1, and go to LDSTALL.
REQ-026 SHALL leave LDSTALL for RUN after exactly one cycle, re-evaluating all hazards in that cycle.
REQ-027 SHALL, when ex_redirect arrives during MEMWAIT, hold it pending (EX is frozen) and service it in the first RUN cycle after MEMWAIT exits.
REQ-028 SHALL increment stall_cnt in every cycle where pc_load=0 and reset=0, saturating at all-ones with no wrap.
REQ-029 SHALL make all outputs combinational from state, counter and inputs; only the state, redirect counter and stall_cnt are registered.

Reset
REQ-030 SHALL, while reset=1, force all loads to 0 and both flushes to 1.
REQ-031 SHALL set state=RUN, redirect counter=0 and stall_cnt=0 on the edge where reset=1.
REQ-032 SHALL, on reset asserted in any state (including mid-MEMWAIT or mid-REDIR), abort that state with no pending redirect retained.

Structure
REQ-033 SHALL take opcode constants (LW, SW, AR, BEQ, BNE, EMPTY) from the shared opcode include.
REQ-034 SHALL define the state encodings and the EMPTY bubble value as constants in a shared control include, pipe_ctrl.vh.
REQ-035 SHALL place the saturating counter in sub-module sat_counter (parameter width W; ports clk, reset, inc, value).

Verification
REQ-036 SHALL cover: reset held 2 cycles, then released -> loads=0 and flushes=1 during reset; ctrl_state=0 and stall_cnt=0 on the first free cycle.
REQ-037 SHALL cover: LW r5 in EX and AR with rs=5 in ID -> one cycle with pc_load=0 and id_ex_flush=1, then RUN; stall_cnt=1; also, LW r0 -> no stall.
REQ-038 SHALL cover: ex_redirect=1 with FLUSH_CYCLES=2 -> both flushes high for 1 cycle, REDIR for 2 cycles, and a concurrent load-use pattern ignored.
REQ-039 SHALL cover: mem_req=1 with mem_ready low for 3 cycles -> loads=0 for 3 cycles, ctrl_state=3, stall_cnt=3, loads=1 on the ready cycle.
REQ-040 SHALL cover: ex_redirect, load-use and memory wait all asserted in the same cycle -> MEMWAIT first, then REDIR after ready, and no LDSTALL.
REQ-041 SHALL cover: CNT_W=4 with 20 stalled cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode values, control-state encodings and pipeline-enable bundles for the hazard controller.
// The EMPTY opcode is the bubble that a flushed pipeline register holds.
package pipe_hazard_ctrl_pkg;

  localparam logic [5:0] OP_AR    = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_EMPTY = 6'h3F;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_REDIR   = 2'd1,
    ST_LDSTALL = 2'd2,
    ST_MEMWAIT = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic id_ex_load;
    logic ex_mem_load;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_RUN     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_out_t CTRL_RESET   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctrl_out_t CTRL_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_out_t CTRL_REDIR   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_out_t CTRL_LDSTALL = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // rt is only a source for register-register ops, branches and stores.
  function automatic logic load_use_hazard(
    input logic [5:0] id_op,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic [5:0] ex_op,
    input logic [4:0] ex_rt
  );
    logic w_uses_rt;
    w_uses_rt = (id_op == OP_AR) || (id_op == OP_BEQ) || (id_op == OP_BNE) || (id_op == OP_SW);
    return (ex_op == OP_LW) && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (w_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; one-cycle update latency.
// Holds at all-ones once reached, never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else if (inc && (r_value != {W{1'b1}})) begin
      r_value <= r_value + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign value = r_value;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, redirect flush and load-use stall; enables are combinational.
// Priority is memory wait, then redirect, then load-use; a redirect seen while frozen is replayed after the freeze.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [5:0]       ex_opcode,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] LP_REDIR_INIT = 2'(FLUSH_CYCLES - 1);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;
  logic [1:0]  r_redir_cnt;
  logic [1:0]  w_redir_cnt_nxt;
  ctrl_out_t   w_ctrl;
  logic        w_mem_wait;
  logic        w_load_use;
  logic        w_redir_req;
  logic        w_stall_inc;

  assign w_mem_wait = mem_req & ~mem_ready;
  assign w_load_use = load_use_hazard(id_opcode, id_rs, id_rt, ex_opcode, ex_rt);
  // Outside REDIR a non-zero redirect counter marks a redirect deferred by a memory freeze.
  assign w_redir_req = ex_redirect | (r_redir_cnt != 2'd0);

  always_comb begin
    w_ctrl          = CTRL_RUN;
    w_state_nxt     = r_state;
    w_redir_cnt_nxt = r_redir_cnt;
    if (reset) begin
      w_ctrl          = CTRL_RESET;
      w_state_nxt     = ST_RUN;
      w_redir_cnt_nxt = 2'd0;
    end else begin
      case (r_state)
        ST_REDIR: begin
          if (w_mem_wait) begin
            w_ctrl          = CTRL_FREEZE;
            w_state_nxt     = ST_MEMWAIT;
            w_redir_cnt_nxt = 2'd0;
          end else if (r_redir_cnt == 2'd0) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_redir_cnt_nxt = r_redir_cnt - 2'd1;
          end
        end
        ST_MEMWAIT: begin
          if (ex_redirect) begin
            w_redir_cnt_nxt = 2'd1;
          end
          if (mem_ready) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_ctrl = CTRL_FREEZE;
          end
        end
        default: begin
          if (w_mem_wait) begin
            w_ctrl      = CTRL_FREEZE;
            w_state_nxt = ST_MEMWAIT;
            if (ex_redirect) begin
              w_redir_cnt_nxt = 2'd1;
            end
          end else if (w_redir_req) begin
            w_ctrl          = CTRL_REDIR;
            w_state_nxt     = ST_REDIR;
            w_redir_cnt_nxt = LP_REDIR_INIT;
          end else if (w_load_use) begin
            w_ctrl      = CTRL_LDSTALL;
            w_state_nxt = ST_LDSTALL;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_redir_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_redir_cnt <= w_redir_cnt_nxt;
    end
  end

  assign w_stall_inc = ~w_ctrl.pc_load & ~reset;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_stall_inc),
    .value(stall_cnt)
  );

  assign pc_load     = w_ctrl.pc_load;
  assign if_id_load  = w_ctrl.if_id_load;
  assign id_ex_load  = w_ctrl.id_ex_load;
  assign ex_mem_load = w_ctrl.ex_mem_load;
  assign if_id_flush = w_ctrl.if_id_flush;
  assign id_ex_flush = w_ctrl.id_ex_flush;
  assign ctrl_state  = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: u_dut_a runs FLUSH_CYCLES=2/CNT_W=4, u_dut_b the defaults, both on shared stimulus.
// Control vectors are {pc, if_id, id_ex, ex_mem loads, if_id_flush, id_ex_flush}.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] id_opcode, ex_opcode;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic ex_redirect, mem_req, mem_ready;

  logic pc_load_a, if_id_load_a, id_ex_load_a, ex_mem_load_a, if_id_flush_a, id_ex_flush_a;
  logic pc_load_b, if_id_load_b, id_ex_load_b, ex_mem_load_b, if_id_flush_b, id_ex_flush_b;
  logic [1:0]  state_a, state_b;
  logic [3:0]  stall_a;
  logic [15:0] stall_b;
  logic [5:0]  ctl_a, ctl_b;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_opcode(ex_opcode), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(pc_load_a), .if_id_load(if_id_load_a), .id_ex_load(id_ex_load_a),
    .ex_mem_load(ex_mem_load_a), .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a),
    .ctrl_state(state_a), .stall_cnt(stall_a)
  );

  pipe_hazard_ctrl u_dut_b (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_opcode(ex_opcode), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(pc_load_b), .if_id_load(if_id_load_b), .id_ex_load(id_ex_load_b),
    .ex_mem_load(ex_mem_load_b), .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b),
    .ctrl_state(state_b), .stall_cnt(stall_b)
  );

  assign ctl_a = {pc_load_a, if_id_load_a, id_ex_load_a, ex_mem_load_a, if_id_flush_a, id_ex_flush_a};
  assign ctl_b = {pc_load_b, if_id_load_b, id_ex_load_b, ex_mem_load_b, if_id_flush_b, id_ex_flush_b};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] idop, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [5:0] exop, input logic [4:0] exrt,
                       input logic redir, input logic req, input logic rdy);
    id_opcode   = idop;
    id_rs       = rs;
    id_rt       = rt;
    ex_opcode   = exop;
    ex_rt       = exrt;
    ex_redirect = redir;
    mem_req     = req;
    mem_ready   = rdy;
  endtask

  task automatic idle();
    drive(OP_AR, 5'd1, 5'd2, OP_EMPTY, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_ctl_a", 32'(ctl_a), 32'(6'b000011));
      chk("rst_ctl_b", 32'(ctl_b), 32'(6'b000011));
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    settle();
    chk("free_state", 32'(state_a), 32'd0);
    chk("free_stall", 32'(stall_a), 32'd0);
    chk("free_ctl", 32'(ctl_a), 32'(6'b111100));
    tick();

    // Load-use on rs, then r0 (ignored), SW on rt, and LW in ID whose rt is not a source.
    drive(OP_AR, 5'd5, 5'd2, OP_LW, 5'd5, 1'b0, 1'b0, 1'b1);
    settle();
    chk("ldu_ctl", 32'(ctl_a), 32'(6'b001101));
    tick();
    drive(OP_AR, 5'd5, 5'd2, OP_EMPTY, 5'd0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("ldu_state", 32'(state_a), 32'd2);
    chk("ldu_reeval_ctl", 32'(ctl_a), 32'(6'b111100));
    chk("ldu_stall", 32'(stall_a), 32'd1);
    tick();
    drive(OP_AR, 5'd0, 5'd2, OP_LW, 5'd0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("ldu_back_run", 32'(state_a), 32'd0);
    chk("lw_r0_ctl", 32'(ctl_a), 32'(6'b111100));
    tick();
    drive(OP_SW, 5'd1, 5'd7, OP_LW, 5'd7, 1'b0, 1'b0, 1'b1);
    settle();
    chk("sw_rt_ctl", 32'(ctl_a), 32'(6'b001101));
    tick();
    drive(OP_LW, 5'd1, 5'd7, OP_LW, 5'd7, 1'b0, 1'b0, 1'b1);
    settle();
    chk("lw_rt_ctl", 32'(ctl_a), 32'(6'b111100));
    chk("lw_rt_stall", 32'(stall_a), 32'd2);
    tick();

    // Redirect with a concurrent load-use pattern.
    do_reset();
    drive(OP_AR, 5'd5, 5'd2, OP_LW, 5'd5, 1'b1, 1'b0, 1'b1);
    settle();
    chk("redir_ctl", 32'(ctl_a), 32'(6'b111111));
    tick();
    settle();
    chk("redir1_state_a", 32'(state_a), 32'd1);
    chk("redir1_ctl_a", 32'(ctl_a), 32'(6'b111100));
    chk("redir1_state_b", 32'(state_b), 32'd1);
    tick();
    drive(OP_AR, 5'd5, 5'd2, OP_LW, 5'd5, 1'b0, 1'b0, 1'b1);
    settle();
    chk("redir2_state_a", 32'(state_a), 32'd1);
    chk("redir2_ctl_a", 32'(ctl_a), 32'(6'b111100));
    chk("redir2_state_b", 32'(state_b), 32'd0);
    chk("redir2_ctl_b", 32'(ctl_b), 32'(6'b001101));
    tick();
    idle();
    settle();
    chk("redir_done_a", 32'(state_a), 32'd0);
    chk("redir_stall_a", 32'(stall_a), 32'd0);
    chk("redir_ldstall_b", 32'(state_b), 32'd2);
    tick();

    // Memory wait for three cycles.
    do_reset();
    drive(OP_AR, 5'd1, 5'd2, OP_EMPTY, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mw_ctl", 32'(ctl_a), 32'(6'b000000));
      chk("mw_state", 32'(state_a), (i == 0) ? 32'd0 : 32'd3);
      tick();
    end
    mem_ready = 1'b1;
    settle();
    chk("mw_ready_state", 32'(state_a), 32'd3);
    chk("mw_ready_ctl", 32'(ctl_a), 32'(6'b111100));
    chk("mw_stall", 32'(stall_a), 32'd3);
    tick();
    settle();
    chk("mw_req_rdy_ctl", 32'(ctl_a), 32'(6'b111100));
    chk("mw_exit_state", 32'(state_a), 32'd0);
    tick();

    // All three events at once; the redirect leaves EX on the ready cycle.
    do_reset();
    drive(OP_AR, 5'd5, 5'd2, OP_LW, 5'd5, 1'b1, 1'b1, 1'b0);
    settle();
    chk("all_ctl", 32'(ctl_a), 32'(6'b000000));
    tick();
    settle();
    chk("all_state", 32'(state_a), 32'd3);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("all_ready_ctl", 32'(ctl_a), 32'(6'b111100));
    tick();
    drive(OP_AR, 5'd5, 5'd2, OP_LW, 5'd5, 1'b0, 1'b0, 1'b1);
    settle();
    chk("pend_state", 32'(state_a), 32'd0);
    chk("pend_ctl", 32'(ctl_a), 32'(6'b111111));
    tick();
    settle();
    chk("pend_redir1", 32'(state_a), 32'd1);
    tick();
    settle();
    chk("pend_redir2", 32'(state_a), 32'd1);
    tick();
    idle();
    settle();
    chk("pend_run", 32'(state_a), 32'd0);
    chk("pend_stall", 32'(stall_a), 32'd2);
    tick();

    // Stall counter saturation over 20 stalled cycles.
    do_reset();
    drive(OP_AR, 5'd1, 5'd2, OP_EMPTY, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (20) tick();
    settle();
    chk("sat_a", 32'(stall_a), 32'd15);
    chk("sat_b", 32'(stall_b), 32'd20);
    tick();

    // Reset during MEMWAIT with a redirect pending leaves nothing behind.
    drive(OP_AR, 5'd1, 5'd2, OP_EMPTY, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    idle();
    settle();
    chk("mid_rst_ctl", 32'(ctl_a), 32'(6'b000011));
    tick();
    reset = 1'b0;
    settle();
    chk("mid_rst_state", 32'(state_a), 32'd0);
    chk("mid_rst_ctl_run", 32'(ctl_a), 32'(6'b111100));
    chk("mid_rst_stall", 32'(stall_a), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
